// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encodings,
// state width, default access latency and the counter preload helper.
package memory_responder_pkg;

  localparam int MEM_ST_SIZE = 2;
  localparam int MEM_LATENCY = 2;
  localparam int MEM_CNT_BITS = 4;

  typedef enum logic [MEM_ST_SIZE-1:0] {
    MEM_ST_IDLE      = 2'd0,
    MEM_ST_BUSY      = 2'd1,
    MEM_ST_RESP      = 2'd2,
    MEM_ST_WAIT_DROP = 2'd3
  } mem_state_e;

  // Value loaded into the down-counter so that BUSY lasts exactly lat cycles.
  function automatic logic [MEM_CNT_BITS-1:0] latency_preload(input int lat);
    return MEM_CNT_BITS'(lat - 1);
  endfunction

endpackage

// File: rtl/memory_responder_mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so preloaded data survives a reset.
module mem_array
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem_r [0:(2**ADDR_BITS)-1];

  // Synchronous write of the selected word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: latches a single-word read/write request, waits a
// fixed latency in BUSY, completes with a one-cycle pulse in RESP, then waits
// for the requester to drop its request so a held request is served once.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = MEM_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] write_data,
  output logic [WORD_SIZE-1:0] read_data,
  output logic                 input_ready,
  output logic                 ack_output,
  output logic                 busy,
  output logic                 req_err,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data
);

  localparam logic [MEM_CNT_BITS-1:0] CNT_PRELOAD = latency_preload(LATENCY);

  mem_state_e              state_r;
  logic [MEM_CNT_BITS-1:0] count_r;
  logic                    op_write_r;
  logic [ADDR_BITS-1:0]    addr_r;
  logic [WORD_SIZE-1:0]    data_r;

  logic                    we_s;
  logic [ADDR_BITS-1:0]    waddr_s;
  logic [WORD_SIZE-1:0]    wdata_s;
  logic [WORD_SIZE-1:0]    rd_word_s;
  logic                    any_req_s;
  logic                    unused_addr_s;

  assign any_req_s     = read_m | write_m;
  // Upper address bits are intentionally ignored: addresses wrap.
  assign unused_addr_s = ^address;

  // Write-port select: a completing write has priority; a backdoor load is
  // only taken in IDLE when no request competes; nothing writes during reset.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = load_addr;
    wdata_s = load_data;
    if (reset) begin
      we_s = 1'b0;
    end else if ((state_r == MEM_ST_RESP) && op_write_r) begin
      we_s    = 1'b1;
      waddr_s = addr_r;
      wdata_s = data_r;
    end else if ((state_r == MEM_ST_IDLE) && load_en && !any_req_s) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  mem_array #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_BITS(ADDR_BITS)
  ) u_mem_array (
    .clk  (clk),
    .we   (we_s),
    .waddr(waddr_s),
    .wdata(wdata_s),
    .raddr(addr_r),
    .rdata(rd_word_s)
  );

  // Request FSM with latency counter, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= MEM_ST_IDLE;
      count_r     <= {MEM_CNT_BITS{1'b0}};
      op_write_r  <= 1'b0;
      addr_r      <= {ADDR_BITS{1'b0}};
      data_r      <= {WORD_SIZE{1'b0}};
      read_data   <= {WORD_SIZE{1'b0}};
      input_ready <= 1'b0;
      ack_output  <= 1'b0;
      busy        <= 1'b0;
      req_err     <= 1'b0;
    end else begin
      case (state_r)
        MEM_ST_IDLE: begin
          input_ready <= 1'b0;
          ack_output  <= 1'b0;
          if (any_req_s) begin
            // Read wins when both are raised; the conflict is flagged.
            op_write_r <= write_m & ~read_m;
            addr_r     <= address[ADDR_BITS-1:0];
            data_r     <= write_data;
            count_r    <= CNT_PRELOAD;
            busy       <= 1'b1;
            state_r    <= MEM_ST_BUSY;
            if (read_m && write_m) begin
              req_err <= 1'b1;
            end
          end
        end
        MEM_ST_BUSY: begin
          if (count_r == {MEM_CNT_BITS{1'b0}}) begin
            state_r <= MEM_ST_RESP;
            if (op_write_r) begin
              ack_output <= 1'b1;
            end else begin
              input_ready <= 1'b1;
              read_data   <= rd_word_s;
            end
          end else begin
            count_r <= count_r - {{(MEM_CNT_BITS-1){1'b0}}, 1'b1};
          end
        end
        MEM_ST_RESP: begin
          input_ready <= 1'b0;
          ack_output  <= 1'b0;
          state_r     <= MEM_ST_WAIT_DROP;
        end
        MEM_ST_WAIT_DROP: begin
          if (!any_req_s) begin
            busy    <= 1'b0;
            state_r <= MEM_ST_IDLE;
          end
        end
        default: begin
          input_ready <= 1'b0;
          ack_output  <= 1'b0;
          busy        <= 1'b0;
          state_r     <= MEM_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with hand-computed expectations.
module tb_memory_responder;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 read_m = 1'b0;
  logic                 write_m = 1'b0;
  logic [WORD_SIZE-1:0] address = 16'h0000;
  logic [WORD_SIZE-1:0] write_data = 16'h0000;
  logic [WORD_SIZE-1:0] read_data;
  logic                 input_ready;
  logic                 ack_output;
  logic                 busy;
  logic                 req_err;
  logic                 load_en = 1'b0;
  logic [ADDR_BITS-1:0] load_addr = 8'h00;
  logic [WORD_SIZE-1:0] load_data = 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  memory_responder #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_BITS(ADDR_BITS),
    .LATENCY  (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read_m     (read_m),
    .write_m    (write_m),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .input_ready(input_ready),
    .ack_output (ack_output),
    .busy       (busy),
    .req_err    (req_err),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [ADDR_BITS-1:0] a, input logic [WORD_SIZE-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Hold a request for 6 cycles, record first completion cycle and pulse
  // counts, then drop the request and give WAIT_DROP one cycle to exit.
  task automatic access(input logic rd, input logic wr,
                        input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] wd,
                        output int lat, output logic [WORD_SIZE-1:0] rdata,
                        output int irs, output int acks);
    read_m = rd;
    write_m = wr;
    address = a;
    write_data = wd;
    lat = 0;
    irs = 0;
    acks = 0;
    rdata = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (input_ready) begin
        if (irs == 0 && acks == 0) lat = k;
        if (irs == 0) rdata = read_data;
        irs++;
      end
      if (ack_output) begin
        if (irs == 0 && acks == 0) lat = k;
        acks++;
      end
    end
    read_m = 1'b0;
    write_m = 1'b0;
    tick();
  endtask

  int lat;
  int irs;
  int acks;
  int cnt;
  logic [WORD_SIZE-1:0] rdv;

  initial begin
    // Reset with preloaded word.
    tick();
    tick();
    reset = 1'b0;
    load(8'h03, 16'h1234);
    reset = 1'b1;
    tick();
    check("rst_read_data", read_data, 16'h0000);
    check("rst_input_ready", input_ready, 1'b0);
    check("rst_ack_output", ack_output, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_err", req_err, 1'b0);
    reset = 1'b0;
    tick();

    // Read latency, held request, busy release.
    read_m = 1'b1;
    address = 16'h0003;
    tick();
    check("rd_busy_T", busy, 1'b1);
    check("rd_ir_T", input_ready, 1'b0);
    tick();
    check("rd_ir_T1", input_ready, 1'b0);
    tick();
    check("rd_ir_T2", input_ready, 1'b1);
    check("rd_data_T2", read_data, 16'h1234);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (input_ready) cnt++;
    end
    check("rd_no_second_pulse", cnt, 0);
    check("rd_busy_held", busy, 1'b1);
    check("rd_data_held", read_data, 16'h1234);
    read_m = 1'b0;
    tick();
    check("rd_busy_drop", busy, 1'b0);

    // Write then read, including wrapped address.
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, rdv, irs, acks);
    check("wr_ack_latency", lat, LATENCY + 1);
    check("wr_ack_count", acks, 1);
    check("wr_no_ir", irs, 0);
    check("wr_busy_idle", busy, 1'b0);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, lat, rdv, irs, acks);
    check("rd10_data", rdv, 16'hBEEF);
    check("rd10_ir_count", irs, 1);
    access(1'b1, 1'b0, 16'h0110, 16'h0000, lat, rdv, irs, acks);
    check("rd_wrap_data", rdv, 16'hBEEF);

    // Simultaneous read and write requests.
    load(8'h05, 16'h0505);
    access(1'b1, 1'b1, 16'h0005, 16'hAAAA, lat, rdv, irs, acks);
    check("both_ir_latency", lat, LATENCY + 1);
    check("both_read_data", rdv, 16'h0505);
    check("both_no_ack", acks, 0);
    check("both_req_err", req_err, 1'b1);
    access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, rdv, irs, acks);
    check("both_mem5_kept", rdv, 16'h0505);
    check("both_req_err_sticky", req_err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("req_err_cleared", req_err, 1'b0);

    // Reset during the second BUSY cycle of a write.
    load(8'h07, 16'h0707);
    write_m = 1'b1;
    address = 16'h0007;
    write_data = 16'h5555;
    tick();
    tick();
    reset = 1'b1;
    write_m = 1'b0;
    tick();
    check("abort_ack", ack_output, 1'b0);
    check("abort_busy", busy, 1'b0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ack_output) cnt++;
    end
    check("abort_no_late_ack", cnt, 0);
    access(1'b1, 1'b0, 16'h0007, 16'h0000, lat, rdv, irs, acks);
    check("abort_mem7_kept", rdv, 16'h0707);

    // Backdoor load colliding with a request, and load during BUSY.
    load(8'h09, 16'h0909);
    read_m = 1'b1;
    address = 16'h0009;
    load_en = 1'b1;
    load_addr = 8'h09;
    load_data = 16'h0F0F;
    tick();
    tick();
    load_en = 1'b0;
    tick();
    check("bd_ir", input_ready, 1'b1);
    check("bd_read_data", read_data, 16'h0909);
    read_m = 1'b0;
    tick();
    tick();
    access(1'b1, 1'b0, 16'h0009, 16'h0000, lat, rdv, irs, acks);
    check("bd_mem9_kept", rdv, 16'h0909);
    check("bd_ir_latency", lat, LATENCY + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Memory-side responder for the multi-cycle CPU's memory port. It accepts single-word read and write requests from the datapath, models a fixed access latency with a down-counter, and completes each request with a one-cycle completion pulse. It holds the backing word storage and has a backdoor preload port for benches. It is the other end of the datapath's read/write request interface.

## Interface

Parameters:
- `WORD_SIZE`, 16, data and address width; matches the `const.v` value.
- `ADDR_BITS`, 8, index bits; storage holds 2^ADDR_BITS words.
- `LATENCY`, 2, number of BUSY cycles per access; legal range 1..15.

Ports:
- `clk`  in  1  single clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read_m`  in  1  read request; held high by the requester until `input_ready`.
- `write_m`  in  1  write request; held high by the requester until `ack_output`.
- `address`  in  WORD_SIZE  word address; only the low ADDR_BITS bits are used.
- `write_data`  in  WORD_SIZE  data for a write request.
- `read_data`  out  WORD_SIZE  read result; valid while `input_ready`=1 and held afterwards.
- `input_ready`  out  1  one-cycle pulse marking read completion.
- `ack_output`  out  1  one-cycle pulse marking write completion.
- `busy`  out  1  high in every state except IDLE.
- `req_err`  out  1  sticky flag: `read_m` and `write_m` were both high when sampled in IDLE.
- `load_en`  in  1  backdoor write enable; honoured only in IDLE.
- `load_addr`  in  ADDR_BITS  backdoor index.
- `load_data`  in  WORD_SIZE  backdoor data.

## Operation

- States: IDLE, BUSY, RESP, WAIT_DROP.
- **IDLE**
  - If `read_m` or `write_m` is high: latch the operation, `address[ADDR_BITS-1:0]` and `write_data`; load the counter with LATENCY-1; go to BUSY.
  - If both requests are high: the read wins and `req_err` is set.
  - Otherwise, if `load_en` is high: write `mem[load_addr]=load_data`.
  - A request and `load_en` in the same cycle: the request wins and the load is dropped.
- **BUSY**
  - If the counter is 0, go to RESP; otherwise decrement.
  - Request inputs are ignored; only the latched values are used.
- **RESP**, lasting exactly one cycle:
  - Read: drive `read_data=mem[latched_addr]` and pulse `input_ready`.
  - Write: write `mem[latched_addr]=latched_data` and pulse `ack_output`.
  - Go to WAIT_DROP.
- **WAIT_DROP**
  - Stay until `read_m` and `write_m` are both 0, then go to IDLE.
  - This prevents a held request from being served twice.
- Addresses wrap: `address` 0x0105 with ADDR_BITS=8 accesses word 0x05.
- Storage reads are combinational from the array and registered into `read_data` at the RESP edge. Storage writes are synchronous.
- **Reset**, whether idle or mid-access:
  - Goes to IDLE and aborts any pending access; a write pending in BUSY is not performed.
  - Clears `read_data`, `input_ready`, `ack_output`, `req_err` and the counter.
  - Storage contents are not cleared.

## Timing

- Request first sampled high in IDLE at edge T:
  - BUSY covers cycles T+1..T+LATENCY.
  - RESP is the cycle after edge T+LATENCY, so `input_ready`/`ack_output` are high for exactly one cycle, starting LATENCY+1 cycles after the request was sampled.
- For a read, `read_data` updates at the same edge that raises `input_ready`.
- For a write, the storage updates at the edge ending RESP. A read issued after WAIT_DROP returns the new value.
- Fastest back-to-back rate: request, LATENCY+1 cycles to completion, at least 1 cycle in WAIT_DROP (requests low), then a new request.
- `busy` rises on the cycle after the request is sampled and falls when the state returns to IDLE.
- Reset values:
  - `read_data`=0, `input_ready`=0, `ack_output`=0, `busy`=0, `req_err`=0.
  - state=IDLE.

## Structure

- Additions to `const.v`: MEM_ST_IDLE/BUSY/RESP/WAIT_DROP encodings, the MEM_ST_SIZE width, and the default MEM_LATENCY.
- One sub-module, `mem_array`:
  - single synchronous write port shared by the RESP write and the backdoor load, with the select done in the parent;
  - one combinational read port.
- The FSM, latency counter and request latches live in `memory_responder`.

## Test plan

- **Reset:** preload mem[3]=0x1234 and pulse `reset` → all outputs 0 and mem[3] still 0x1234.
- **Read latency:** LATENCY=2; hold `read_m` with address 0x0003 from edge T → `input_ready`=1 for one cycle after edge T+2 with `read_data`=0x1234. `read_m` held 3 more cycles → no second pulse. `busy` drops on the cycle after `read_m` falls.
- **Write then read:** write 0xBEEF to address 0x0010 → `ack_output` pulses once. Then read 0x0010 → 0xBEEF. Then read 0x0110 (wrap) → 0xBEEF.
- **Simultaneous requests:** `read_m`=`write_m`=1 at address 5 with `write_data`=0xAAAA → a read completes (`input_ready`, old mem[5]), mem[5] is unchanged, and `req_err`=1 until reset.
- **Reset mid-write:** write 0x5555 to address 7 and assert `reset` during the second BUSY cycle → mem[7] keeps its old value and no `ack_output` is seen.
- **Backdoor conflict:** `load_en` with `load_addr`=9 and `load_data`=0x0F0F in the same cycle as a read request in IDLE → the load is dropped and mem[9] is unchanged. `load_en` during BUSY is also ignored.
